if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests to the instruction memory over a req/ack handshake.
- Presents {PC+4, instruction} to IF/ID every cycle; presents a bubble (NOP) when no instruction is ready.
- Honours a stall from the hazard unit and a branch redirect from the EX/MEM stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_INC, 4, byte increment per sequential fetch.
- NOP_INSTR, 32'h0000_0000, instruction word driven during bubbles.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the IF/ID-facing outputs.
- redirect  in  1  branch taken; load redirect_pc.
- redirect_pc  in  32  branch target address.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  fetch address, registered; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete.
- imem_rdata  in  32  fetched instruction.
- pc_out  out  32  PC+PC_INC of the presented instruction.
- instr_out  out  32  instruction to IF/ID.
- valid_out  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0.
  - pc_out=0, instr_out=NOP_INSTR, valid_out=0.
  - Skid buffer empty; kill flag clear.
- FSM states:
  - IDLE: no request outstanding. If the buffer is empty and redirect=0: imem_req<=1, imem_addr<=pc, go to WAIT.
  - WAIT: one request outstanding; imem_req and imem_addr held until imem_ack.
  - FULL: skid buffer occupied; no request issued.
- Memory protocol:
  - At most one outstanding request.
  - imem_ack is valid no earlier than the cycle after imem_req rises.
  - On ack with no further request this cycle, imem_req<=0 next cycle.
  - Back-to-back requests allowed: on an accepted ack, if the next request may issue, imem_req stays 1 and imem_addr<=pc+PC_INC.
- Accepted ack (imem_ack=1, kill=0, redirect=0):
  - pc<=pc+PC_INC, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - stall=0: output registers load {pc+PC_INC, imem_rdata, 1}. Latency is ack cycle t -> valid_out at t+1.
  - stall=1: data is written to the 1-entry skid buffer; go to FULL.
- Output register update:
  - Every cycle with stall=0, outputs load in this priority: skid buffer (then buffer cleared) > accepted ack > bubble {0, NOP_INSTR, 0}.
  - valid_out drops to 0 after one cycle if nothing new arrives.
- stall=1:
  - Outputs hold their values.
  - An outstanding request still completes into the buffer.
  - No new request is issued while the buffer is full.
- FULL exit: when stall falls, the buffer drains to the outputs that cycle. Next state is IDLE, so the next request issues on the following cycle.
- redirect=1 (highest priority, overrides stall):
  - pc<=redirect_pc; outputs<=bubble; buffer cleared.
  - If a request is outstanding and imem_ack=0 this cycle: set kill. The later ack is discarded, kill clears on it, and a request to the new pc follows.
  - If imem_ack=1 in the same cycle: data discarded, no kill set.
  - Next request is to redirect_pc no earlier than the following cycle.
- Consecutive redirects: the last one wins. The kill flag does not stack, because at most one request is outstanding.
- Reset mid-request: imem_req drops immediately. The memory must abandon the request; any ack after reset is ignored until the first new request.
- Throughput: with 1-cycle ack latency and no stall, the block sustains one instruction per cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - Fetch FSM state enum {IDLE, WAIT, FULL}.
  - NOP constant 32'h0000_0000.
  - Word-width constant 32.
- One sub-module: fetch_skid_buf, a 1-entry {pc, instr} buffer with load/drain/clear. Everything else is written inline.

Test Plan:
1. Reset release, imem acks every cycle with rdata=addr^32'hA5A5_0000, stall=0 -> valid_out=1 from the 3rd cycle. pc_out sequence 4, 8, 12...; instr_out matches the addr 0, 4, 8... words.
2. stall=1 for 3 cycles while a request is outstanding (ack during the stall) -> outputs frozen, imem_req=0 after the ack, buffer occupied. On release, the buffered word appears next cycle and the following request to the next PC issues.
3. redirect=1, redirect_pc=32'h0000_0100, while WAIT and ack=0; ack arrives 2 cycles later with 32'hDEAD_BEEF -> DEAD_BEEF never appears on instr_out. Next imem_addr=0x100; next valid pc_out=0x104.
4. redirect in the same cycle as ack -> that ack data is dropped, no kill; the next request is to redirect_pc.
5. RESET_PC=32'hFFFF_FFFC -> first instruction pc_out=0, second fetch address 0.
6. rst asserted while imem_req=1 and stall=1 -> imem_req, valid_out and pc_out go to reset values immediately. After release, the first request is to RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and its skid buffer.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FULL
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding slot for the fetch stage.
// Clear beats load, load beats drain.
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    logic         valid_q, valid_d;
    fetch_entry_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack
// handshake and presents {PC+4, instr} or a bubble to IF/ID.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_INC    = 32'd4,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    output logic            valid_out
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [XLEN-1:0] oins_q, oins_d;
    logic            oval_q, oval_d;

    logic            ack_ok;
    logic [XLEN-1:0] pc_inc;
    logic            buf_load, buf_drain, buf_clear, buf_valid;
    fetch_entry_t    buf_din, buf_dout;

    assign pc_inc  = pc_q + PC_INC;
    assign buf_din = '{pc: pc_inc, instr: imem_rdata};

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .drain (buf_drain),
        .clear (buf_clear),
        .din   (buf_din),
        .valid (buf_valid),
        .dout  (buf_dout)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        kill_d    = kill_q;
        opc_d     = opc_q;
        oins_d    = oins_q;
        oval_d    = oval_q;
        ack_ok    = 1'b0;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_clear = 1'b0;

        if (redirect) begin
            pc_d      = redirect_pc;
            opc_d     = '0;
            oins_d    = NOP_INSTR;
            oval_d    = 1'b0;
            buf_clear = 1'b1;
            req_d     = 1'b0;
            kill_d    = 1'b0;
            state_d   = IDLE;
            // Request still in flight: keep it open and drop its data later.
            if (state_q == WAIT && !imem_ack) begin
                req_d   = 1'b1;
                kill_d  = 1'b1;
                state_d = WAIT;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_ack && kill_q) begin
                        kill_d  = 1'b0;
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else if (imem_ack) begin
                        ack_ok = 1'b1;
                        pc_d   = pc_inc;
                        if (stall) begin
                            buf_load = 1'b1;
                            req_d    = 1'b0;
                            state_d  = FULL;
                        end else begin
                            addr_d = pc_inc;
                        end
                    end
                end
                FULL: begin
                    if (!stall) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (!stall) begin
                if (buf_valid) begin
                    opc_d     = buf_dout.pc;
                    oins_d    = buf_dout.instr;
                    oval_d    = 1'b1;
                    buf_drain = 1'b1;
                end else if (ack_ok) begin
                    opc_d  = pc_inc;
                    oins_d = imem_rdata;
                    oval_d = 1'b1;
                end else begin
                    opc_d  = '0;
                    oins_d = NOP_INSTR;
                    oval_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
            kill_q  <= 1'b0;
            opc_q   <= '0;
            oins_q  <= NOP_INSTR;
            oval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
            opc_q   <= opc_d;
            oins_q  <= oins_d;
            oval_q  <= oval_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc_out    = opc_q;
    assign instr_out = oins_q;
    assign valid_out = oval_q;

endmodule
